fp16_unpack: RTL and testbench

- Input stage of the FP16 square-root datapath, directly upstream of the iterative digit-by-digit root stage.
- Accepts one IEEE-754 binary16 word through a valid/ready handshake and classifies it (NaN, ±Inf, zero, negative, finite).
- Normalises subnormals one shift per clock, then presents hidden-bit mantissa and unbiased signed exponent with a single-cycle n_valid strobe.
- Holds off new input until the root stage reports its final result.

---
 rtl/fp16_unpack.sv | 173 +++++++++++++++++
 tb/tb_fp16_unpack.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp16_unpack.sv
// FP16 unpack stage feeding the digit-by-digit square-root core.
// Classifies one binary16 word, normalises subnormals one bit per clock and strobes n_valid.
module fp16_unpack #(
  parameter int BIAS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  input  logic              done_in,
  output logic              n_valid,
  output logic              is_nan_out,
  output logic              is_pinf_out,
  output logic              is_ninf_out,
  output logic              is_num_out,
  output logic              is_zero_out,
  output logic [10:0]       mant_out,
  output logic signed [6:0] exp_out
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ISSUE,
    WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               nValid_q, nValid_d;
  logic               isNan_q, isNan_d;
  logic               isPinf_q, isPinf_d;
  logic               isNinf_q, isNinf_d;
  logic               isNum_q, isNum_d;
  logic               isZero_q, isZero_d;
  logic [10:0]        mant_q, mant_d;
  logic signed [6:0]  exp_q, exp_d;

  logic               inSign;
  logic [4:0]         inExp;
  logic [9:0]         inFrac;
  logic               expAllOnes;
  logic               expAllZeros;
  logic               fracIsZero;

  assign inSign      = in_data[15];
  assign inExp       = in_data[14:10];
  assign inFrac      = in_data[9:0];
  assign expAllOnes  = (inExp == 5'h1f);
  assign expAllZeros = (inExp == 5'h00);
  assign fracIsZero  = (inFrac == 10'h000);

  assign in_ready = (state_q == IDLE) && enable && !rst;

  always_comb begin
    state_d  = state_q;
    nValid_d = 1'b0;
    isNan_d  = isNan_q;
    isPinf_d = isPinf_q;
    isNinf_d = isNinf_q;
    isNum_d  = isNum_q;
    isZero_d = isZero_q;
    mant_d   = mant_q;
    exp_d    = exp_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          isNan_d  = 1'b0;
          isPinf_d = 1'b0;
          isNinf_d = 1'b0;
          isNum_d  = 1'b0;
          isZero_d = 1'b0;
          mant_d   = 11'h000;
          exp_d    = 7'sd0;
          state_d  = ISSUE;
          nValid_d = 1'b1;
          if (expAllOnes && !fracIsZero) begin
            isNan_d = 1'b1;
          end else if (expAllOnes) begin
            isPinf_d = !inSign;
            isNinf_d = inSign;
          end else if (expAllZeros && fracIsZero) begin
            isNum_d  = 1'b1;
            isZero_d = 1'b1;
          end else if (inSign) begin
            // Negative nonzero finite: left unclassified so the root stage yields NaN.
            isNum_d = 1'b0;
          end else if (expAllZeros) begin
            isNum_d  = 1'b1;
            mant_d   = {1'b0, inFrac};
            exp_d    = 7'(1 - BIAS);
            state_d  = NORM;
            nValid_d = 1'b0;
          end else begin
            isNum_d = 1'b1;
            mant_d  = {1'b1, inFrac};
            exp_d   = $signed({2'b00, inExp}) - 7'(BIAS);
          end
        end
      end

      NORM: begin
        mant_d = {mant_q[9:0], 1'b0};
        exp_d  = exp_q - 7'sd1;
        if (mant_q[9] || (mant_q == 11'h000)) begin
          state_d  = ISSUE;
          nValid_d = 1'b1;
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (done_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A low enable behaves like reset but takes effect on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      nValid_q <= 1'b0;
      isNan_q  <= 1'b0;
      isPinf_q <= 1'b0;
      isNinf_q <= 1'b0;
      isNum_q  <= 1'b0;
      isZero_q <= 1'b0;
      mant_q   <= 11'h000;
      exp_q    <= 7'sd0;
    end else if (!enable) begin
      state_q  <= IDLE;
      nValid_q <= 1'b0;
      isNan_q  <= 1'b0;
      isPinf_q <= 1'b0;
      isNinf_q <= 1'b0;
      isNum_q  <= 1'b0;
      isZero_q <= 1'b0;
      mant_q   <= 11'h000;
      exp_q    <= 7'sd0;
    end else begin
      state_q  <= state_d;
      nValid_q <= nValid_d;
      isNan_q  <= isNan_d;
      isPinf_q <= isPinf_d;
      isNinf_q <= isNinf_d;
      isNum_q  <= isNum_d;
      isZero_q <= isZero_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
    end
  end

  assign n_valid     = nValid_q;
  assign is_nan_out  = isNan_q;
  assign is_pinf_out = isPinf_q;
  assign is_ninf_out = isNinf_q;
  assign is_num_out  = isNum_q;
  assign is_zero_out = isZero_q;
  assign mant_out    = mant_q;
  assign exp_out     = exp_q;

endmodule

// File: tb/tb_fp16_unpack.sv
// Directed testbench for fp16_unpack: table of FP16 words with hand-computed fields,
// plus reset-mid-normalisation and enable-clear sequences.
module tb_fp16_unpack;

  typedef struct {
    logic [15:0] data;
    logic [10:0] mant;
    int          expv;
    logic [4:0]  flags;
    int          lat;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              done_in;
  logic              n_valid;
  logic              is_nan_out;
  logic              is_pinf_out;
  logic              is_ninf_out;
  logic              is_num_out;
  logic              is_zero_out;
  logic [10:0]       mant_out;
  logic signed [6:0] exp_out;

  int   checks;
  int   failures;
  vec_t vecs[15];

  fp16_unpack #(.BIAS(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .done_in     (done_in),
    .n_valid     (n_valid),
    .is_nan_out  (is_nan_out),
    .is_pinf_out (is_pinf_out),
    .is_ninf_out (is_ninf_out),
    .is_num_out  (is_num_out),
    .is_zero_out (is_zero_out),
    .mant_out    (mant_out),
    .exp_out     (exp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    in_data  = word;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  function automatic logic [4:0] flagVec();
    return {is_nan_out, is_pinf_out, is_ninf_out, is_num_out, is_zero_out};
  endfunction

  initial begin
    int          cycles;
    logic [10:0] heldMant;
    logic        sawStrobe;

    checks   = 0;
    failures = 0;

    // flags = {nan, pinf, ninf, num, zero}
    vecs[0]  = '{16'h3C00, 11'h400,   0, 5'b00010,  0};
    vecs[1]  = '{16'h4500, 11'h500,   2, 5'b00010,  0};
    vecs[2]  = '{16'h7BFF, 11'h7FF,  15, 5'b00010,  0};
    vecs[3]  = '{16'h0400, 11'h400, -14, 5'b00010,  0};
    vecs[4]  = '{16'h0001, 11'h400, -24, 5'b00010, 10};
    vecs[5]  = '{16'h0200, 11'h400, -15, 5'b00010,  1};
    vecs[6]  = '{16'h03FF, 11'h7FE, -15, 5'b00010,  1};
    vecs[7]  = '{16'h7E00, 11'h000,   0, 5'b10000,  0};
    vecs[8]  = '{16'hFE00, 11'h000,   0, 5'b10000,  0};
    vecs[9]  = '{16'h7C00, 11'h000,   0, 5'b01000,  0};
    vecs[10] = '{16'hFC00, 11'h000,   0, 5'b00100,  0};
    vecs[11] = '{16'hC000, 11'h000,   0, 5'b00000,  0};
    vecs[12] = '{16'h8001, 11'h000,   0, 5'b00000,  0};
    vecs[13] = '{16'h8000, 11'h000,   0, 5'b00011,  0};
    vecs[14] = '{16'h0000, 11'h000,   0, 5'b00011,  0};

    rst      = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    done_in  = 1'b0;
    #12;
    checkOutput("reset_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_nvalid", 32'(n_valid), 32'd0);
    checkOutput("reset_mant", 32'(mant_out), 32'd0);
    checkOutput("reset_exp", 32'(exp_out), 32'd0);
    checkOutput("reset_flags", 32'(flagVec()), 32'd0);
    rst = 1'b0;
    tick();

    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    checkOutput("idle_done_ignored_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_done_ignored_nvalid", 32'(n_valid), 32'd0);

    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("v%0d_ready_idle", i), 32'(in_ready), 32'd1);
      applyStimulus(vecs[i].data);
      cycles = 0;
      while (!n_valid && cycles < 30) begin
        tick();
        cycles++;
      end
      checkOutput($sformatf("v%0d_latency", i), 32'(cycles), 32'(vecs[i].lat));
      checkOutput($sformatf("v%0d_mant", i), 32'(mant_out), 32'(vecs[i].mant));
      checkOutput($sformatf("v%0d_exp", i), 32'(exp_out), 32'(vecs[i].expv));
      checkOutput($sformatf("v%0d_flags", i), 32'(flagVec()), 32'(vecs[i].flags));
      checkOutput($sformatf("v%0d_ready_busy", i), 32'(in_ready), 32'd0);
      heldMant = vecs[i].mant;

      in_valid = 1'b1;
      in_data  = 16'h1234;
      tick();
      checkOutput($sformatf("v%0d_nvalid_once", i), 32'(n_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      checkOutput($sformatf("v%0d_wait_ready", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("v%0d_wait_mant", i), 32'(mant_out), 32'(heldMant));
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checkOutput($sformatf("v%0d_ready_after_done", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("v%0d_idle_mant", i), 32'(mant_out), 32'(heldMant));
    end

    applyStimulus(16'h3C00);
    checkOutput("en_issue", 32'(n_valid), 32'd1);
    tick();
    enable = 1'b0;
    #1;
    checkOutput("en_ready_low", 32'(in_ready), 32'd0);
    tick();
    checkOutput("en_clear_mant", 32'(mant_out), 32'd0);
    checkOutput("en_clear_flags", 32'(flagVec()), 32'd0);
    checkOutput("en_clear_nvalid", 32'(n_valid), 32'd0);
    enable = 1'b1;
    #1;
    checkOutput("en_back_idle", 32'(in_ready), 32'd1);
    tick();

    applyStimulus(16'h0003);
    tick();
    tick();
    checkOutput("rstnorm_mant", 32'(mant_out), 32'h00C);
    checkOutput("rstnorm_exp", 32'(exp_out), 32'(-16));
    checkOutput("rstnorm_nvalid", 32'(n_valid), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rstnorm_ready", 32'(in_ready), 32'd0);
    checkOutput("rstnorm_clear_mant", 32'(mant_out), 32'd0);
    checkOutput("rstnorm_clear_exp", 32'(exp_out), 32'd0);
    checkOutput("rstnorm_clear_flags", 32'(flagVec()), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rstnorm_ready_release", 32'(in_ready), 32'd1);
    sawStrobe = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (n_valid) sawStrobe = 1'b1;
    end
    checkOutput("rstnorm_no_strobe", 32'(sawStrobe), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
